// File: rtl/branch_resolve_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl_pkg
// Shared definitions for the ID-stage branch controller:
//   - branch op encodings as presented on id_br_op
//   - control codes driven to the shared compare unit
//   - FSM state enum for the hazard-stall tracker
//   - helpers to classify a branch op and map it to a compare code
// ---------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

    // Branch op encodings (110/111 are reserved and behave like "none")
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;

    // Compare unit control codes
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NE   = 3'b000;
    localparam logic [2:0] CMP_LEZ  = 3'b110;
    localparam logic [2:0] CMP_GTZ  = 3'b111;
    localparam logic [2:0] CMP_LTZ  = 3'b100;
    localparam logic [2:0] CMP_IDLE = 3'b000;

    // $0 is hardwired to zero: never forwarded, never a hazard source
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_branch_op(input logic [2:0] op);
        return (op >= OP_BEQ) && (op <= OP_BLTZ);
    endfunction

    function automatic logic [2:0] cmp_code(input logic [2:0] op);
        case (op)
            OP_BEQ:  return CMP_EQ;
            OP_BNE:  return CMP_NE;
            OP_BLEZ: return CMP_LEZ;
            OP_BGTZ: return CMP_GTZ;
            OP_BLTZ: return CMP_LTZ;
            default: return CMP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_br_fwd_mux.sv
// ---------------------------------------------------------------------------
// br_fwd_mux
// Per-operand forwarding select and hazard detect for one branch source.
// Ports:
//   used            - this source is actually read by the branch in ID
//   r               - source register number
//   rf_data         - register-file read value
//   ex_*            - EX-stage writer (result not yet available)
//   mem_*           - EX/MEM writer (ALU result forwardable, load data not)
//   wb_*            - MEM/WB writer (write-back value forwardable)
//   opnd            - selected operand value
//   hazard          - value not yet obtainable; branch must stall
// ---------------------------------------------------------------------------
module br_fwd_mux
    import branch_resolve_ctrl_pkg::*;
(
    input  logic        used,
    input  logic [4:0]  r,
    input  logic [31:0] rf_data,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_rd,
    input  logic        mem_regwrite,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] opnd,
    output logic        hazard
);

    logic nz;

    always_comb begin
        nz   = (r != REG_ZERO);
        opnd = rf_data;
        // MEM wins over WB: it holds the younger value of the register
        if (nz && mem_regwrite && !mem_memread && (mem_rd == r)) begin
            opnd = mem_alu_result;
        end else if (nz && wb_regwrite && (wb_rd == r)) begin
            opnd = wb_data;
        end
        // A load in MEM has no data yet, so it stalls just like an EX writer
        hazard = used && nz &&
                 ((ex_regwrite && (ex_rd == r)) || (mem_memread && (mem_rd == r)));
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
// ID-stage branch controller. Decodes the branch op into a compare-unit
// control code, selects forwarded operands, stalls the front end on data
// hazards and redirects the PC / flushes IF/ID on a taken branch. Also keeps
// branch statistics and a sticky stall-overrun flag.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   id_*                       - branch instruction in ID
//   rf_rs_data, rf_rt_data     - register-file reads
//   ex_*, mem_*, wb_*          - downstream writers for forwarding/hazards
//   cmp_ctrl, cmp_a, cmp_b     - drive the shared compare unit
//   cmp_result                 - compare unit result (bit 0 = taken)
//   stall                      - freeze PC and IF/ID, bubble into ID/EX
//   pc_sel, br_target          - PC redirect on a taken branch
//   flush_ifid                 - squash IF/ID on a taken branch
//   br_count, taken_count      - resolved / taken branch counters (wrap)
//   err_overrun                - sticky: stall lasted longer than MAX_STALL
// ---------------------------------------------------------------------------
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_br_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [31:0]      rf_rs_data,
    input  logic [31:0]      rf_rt_data,
    input  logic [31:0]      id_pc_plus4,
    input  logic [15:0]      id_imm,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_alu_result,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic [2:0]       cmp_ctrl,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic [31:0]      cmp_result,
    output logic             stall,
    output logic             pc_sel,
    output logic [31:0]      br_target,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count,
    output logic             err_overrun
);

    // One spare bit so the saturating count can sit above MAX_STALL
    localparam int SC_W = $clog2(MAX_STALL + 1) + 1;

    state_e          state;
    logic [SC_W-1:0] stall_cnt;

    logic        is_br;
    logic        uses_rt;
    logic        haz_rs;
    logic        haz_rt;
    logic        hazard;
    logic        resolve;
    logic        taken;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        unused_cmp_hi;

    assign unused_cmp_hi = ^cmp_result[31:1];

    assign is_br   = id_valid && is_branch_op(id_br_op);
    assign uses_rt = is_br && ((id_br_op == OP_BEQ) || (id_br_op == OP_BNE));

    br_fwd_mux u_fwd_rs (
        .used           (is_br),
        .r              (id_rs),
        .rf_data        (rf_rs_data),
        .ex_regwrite    (ex_regwrite),
        .ex_rd          (ex_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .opnd           (fwd_a),
        .hazard         (haz_rs)
    );

    br_fwd_mux u_fwd_rt (
        .used           (uses_rt),
        .r              (id_rt),
        .rf_data        (rf_rt_data),
        .ex_regwrite    (ex_regwrite),
        .ex_rd          (ex_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .opnd           (fwd_b),
        .hazard         (haz_rt)
    );

    assign hazard  = haz_rs || haz_rt;
    assign stall   = is_br && hazard;
    assign resolve = is_br && !hazard;
    assign taken   = resolve && cmp_result[0];

    assign cmp_ctrl   = is_br ? cmp_code(id_br_op) : CMP_IDLE;
    assign cmp_a      = fwd_a;
    assign cmp_b      = uses_rt ? fwd_b : 32'd0;
    assign pc_sel     = taken;
    assign flush_ifid = taken;
    assign br_target  = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            stall_cnt   <= '0;
            br_count    <= '0;
            taken_count <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (resolve) begin
                br_count <= br_count + 1'b1;
                if (cmp_result[0]) begin
                    taken_count <= taken_count + 1'b1;
                end
            end
            case (state)
                ST_RUN: begin
                    if (stall) begin
                        state     <= ST_WAIT;
                        stall_cnt <= SC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!is_br) begin
                        // Branch squashed from outside: drop tracking quietly
                        state <= ST_RUN;
                    end else if (hazard) begin
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                        if (stall_cnt >= SC_W'(MAX_STALL)) begin
                            err_overrun <= 1'b1;
                        end
                    end else begin
                        state     <= ST_RUN;
                        stall_cnt <= '0;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed vectors drive the ID-stage branch controller; each vector pushes
// its hand-computed expected outputs into a queue and a separate monitor pops
// and compares them mid-cycle. Counters use CNT_W = 4 so wrap is reachable.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [2:0]    id_br_op;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [31:0]   rf_rs_data;
    logic [31:0]   rf_rt_data;
    logic [31:0]   id_pc_plus4;
    logic [15:0]   id_imm;
    logic          ex_regwrite;
    logic [4:0]    ex_rd;
    logic          mem_regwrite;
    logic          mem_memread;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_alu_result;
    logic          wb_regwrite;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic [2:0]    cmp_ctrl;
    logic [31:0]   cmp_a;
    logic [31:0]   cmp_b;
    logic [31:0]   cmp_result;
    logic          stall;
    logic          pc_sel;
    logic [31:0]   br_target;
    logic          flush_ifid;
    logic [CW-1:0] br_count;
    logic [CW-1:0] taken_count;
    logic          err_overrun;

    branch_resolve_ctrl #(.MAX_STALL(2), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_br_op       (id_br_op),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .rf_rs_data     (rf_rs_data),
        .rf_rt_data     (rf_rt_data),
        .id_pc_plus4    (id_pc_plus4),
        .id_imm         (id_imm),
        .ex_regwrite    (ex_regwrite),
        .ex_rd          (ex_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .cmp_ctrl       (cmp_ctrl),
        .cmp_a          (cmp_a),
        .cmp_b          (cmp_b),
        .cmp_result     (cmp_result),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .br_target      (br_target),
        .flush_ifid     (flush_ifid),
        .br_count       (br_count),
        .taken_count    (taken_count),
        .err_overrun    (err_overrun)
    );

    typedef struct {
        int            id;
        logic          st;
        logic          ps;
        logic          fl;
        logic [2:0]    ctrl;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   tgt;
        logic [CW-1:0] bc;
        logic [CW-1:0] tc;
        logic          er;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vid    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s got=%h expected=%h", id, nm, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "stall",       {31'd0, stall},       {31'd0, e.st});
            chk(e.id, "pc_sel",      {31'd0, pc_sel},      {31'd0, e.ps});
            chk(e.id, "flush_ifid",  {31'd0, flush_ifid},  {31'd0, e.fl});
            chk(e.id, "cmp_ctrl",    {29'd0, cmp_ctrl},    {29'd0, e.ctrl});
            chk(e.id, "cmp_a",       cmp_a,                e.a);
            chk(e.id, "cmp_b",       cmp_b,                e.b);
            chk(e.id, "br_target",   br_target,            e.tgt);
            chk(e.id, "br_count",    32'(br_count),        32'(e.bc));
            chk(e.id, "taken_count", 32'(taken_count),     32'(e.tc));
            chk(e.id, "err_overrun", {31'd0, err_overrun}, {31'd0, e.er});
        end
    end

    task automatic idle();
        id_valid = 0; id_br_op = 3'b000; id_rs = 0; id_rt = 0;
        rf_rs_data = 0; rf_rt_data = 0; id_pc_plus4 = 0; id_imm = 0;
        ex_regwrite = 0; ex_rd = 0; mem_regwrite = 0; mem_memread = 0;
        mem_rd = 0; mem_alu_result = 0; wb_regwrite = 0; wb_rd = 0;
        wb_data = 0; cmp_result = 0;
    endtask

    task automatic br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [15:0] imm, input logic res);
        id_valid = 1; id_br_op = op; id_rs = rs; id_rt = rt;
        rf_rs_data = a; rf_rt_data = b; id_pc_plus4 = pc; id_imm = imm;
        cmp_result = {31'd0, res};
    endtask

    // Push the expectation for the inputs currently applied, then advance
    task automatic step(input logic st, input logic ps, input logic fl, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                        input logic [CW-1:0] bc, input logic [CW-1:0] tc, input logic er);
        exp_t e;
        e.id = vid; e.st = st; e.ps = ps; e.fl = fl; e.ctrl = ctrl;
        e.a = a; e.b = b; e.tgt = tgt; e.bc = bc; e.tc = tc; e.er = er;
        vid++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        step(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        reset = 0;

        // beq $0,$0 taken, target 0x100 + (-1<<2) = 0xFC
        idle(); br(3'b001, 0, 0, 0, 0, 32'h100, 16'hFFFF, 1);
        step(0, 1, 1, 3'b001, 32'h0, 32'h0, 32'h0FC, 0, 0, 0);
        idle();
        step(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 1, 0);

        // bne $1,$2 with ALU writer of $2 in EX: one stall, then MEM forward
        idle(); br(3'b010, 1, 2, 32'h11, 32'h22, 32'h200, 16'h0004, 1);
        ex_regwrite = 1; ex_rd = 2;
        step(1, 0, 0, 3'b000, 32'h11, 32'h22, 32'h210, 1, 1, 0);
        idle(); br(3'b010, 1, 2, 32'h11, 32'h22, 32'h200, 16'h0004, 0);
        mem_regwrite = 1; mem_rd = 2; mem_alu_result = 32'h55;
        wb_regwrite = 1; wb_rd = 2; wb_data = 32'h99;
        step(0, 0, 0, 3'b000, 32'h11, 32'h55, 32'h210, 1, 1, 0);

        // bltz $3 after load of $3: load in EX, then MEM, then WB forward
        idle(); br(3'b101, 3, 7, 32'h33, 32'h77, 32'h300, 16'hFFFE, 0);
        ex_regwrite = 1; ex_rd = 3;
        step(1, 0, 0, 3'b100, 32'h33, 32'h0, 32'h2F8, 2, 1, 0);
        idle(); br(3'b101, 3, 7, 32'h33, 32'h77, 32'h300, 16'hFFFE, 0);
        mem_regwrite = 1; mem_memread = 1; mem_rd = 3; mem_alu_result = 32'hDEAD;
        step(1, 0, 0, 3'b100, 32'h33, 32'h0, 32'h2F8, 2, 1, 0);
        idle(); br(3'b101, 3, 7, 32'h33, 32'h77, 32'h300, 16'hFFFE, 1);
        wb_regwrite = 1; wb_rd = 3; wb_data = 32'hFFFF_FFF0;
        step(0, 1, 1, 3'b100, 32'hFFFF_FFF0, 32'h0, 32'h2F8, 2, 1, 0);
        idle();
        step(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 3, 2, 0);

        // beq $4,$5 hazard held 3 cycles: overrun flag sets and sticks
        for (int i = 0; i < 3; i++) begin
            idle(); br(3'b001, 4, 5, 32'h44, 32'h55, 32'h400, 16'h0001, 1);
            ex_regwrite = 1; ex_rd = 4;
            step(1, 0, 0, 3'b001, 32'h44, 32'h55, 32'h404, 3, 2, 0);
        end
        idle(); br(3'b001, 4, 5, 32'h44, 32'h55, 32'h400, 16'h0001, 0);
        step(0, 0, 0, 3'b001, 32'h44, 32'h55, 32'h404, 3, 2, 1);
        idle();
        step(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 4, 2, 1);

        // blez with forwarded rs = 0x80000000; rt ignored
        idle(); br(3'b011, 6, 6, 32'h0, 32'h1234, 32'h500, 16'h0010, 1);
        mem_regwrite = 1; mem_rd = 6; mem_alu_result = 32'h8000_0000;
        step(0, 1, 1, 3'b110, 32'h8000_0000, 32'h0, 32'h540, 4, 2, 1);

        // bgtz $0 with writers to $0: no stall, no forward
        idle(); br(3'b100, 0, 0, 32'h0, 32'h0, 32'h0, 16'h0, 0);
        ex_regwrite = 1; ex_rd = 0; mem_regwrite = 1; mem_rd = 0; mem_alu_result = 32'hABC;
        step(0, 0, 0, 3'b111, 32'h0, 32'h0, 32'h0, 5, 3, 1);

        // reserved op 110 is not a branch even with a hazard on rs
        idle(); br(3'b110, 1, 0, 32'h11, 32'h0, 32'h0, 16'h0, 1);
        ex_regwrite = 1; ex_rd = 1;
        step(0, 0, 0, 3'b000, 32'h11, 32'h0, 32'h0, 6, 3, 1);

        // reset while stalled abandons the branch and clears everything
        idle(); br(3'b001, 1, 0, 32'h11, 32'h0, 32'h0, 16'h0, 1);
        ex_regwrite = 1; ex_rd = 1;
        step(1, 0, 0, 3'b001, 32'h11, 32'h0, 32'h0, 6, 3, 1);
        reset = 1;
        step(1, 0, 0, 3'b001, 32'h11, 32'h0, 32'h0, 6, 3, 1);
        reset = 0;
        idle();
        step(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // counter wrap with 4-bit counters
        for (int i = 0; i < 15; i++) begin
            idle(); br(3'b001, 0, 0, 0, 0, 0, 16'h0, 1);
            step(0, 1, 1, 3'b001, 32'h0, 32'h0, 32'h0, CW'(i), CW'(i), 0);
        end
        idle(); br(3'b001, 0, 0, 0, 0, 0, 16'h0, 0);
        step(0, 0, 0, 3'b001, 32'h0, 32'h0, 32'h0, 15, 15, 0);
        idle(); br(3'b001, 0, 0, 0, 0, 0, 16'h0, 1);
        step(0, 1, 1, 3'b001, 32'h0, 32'h0, 32'h0, 0, 15, 0);
        idle();
        step(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 0, 0);

        chk(-1, "queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
ID-stage branch controller for the pipelined CPU. It owns the shared compare unit, decodes the branch op into the compare control code, and selects forwarded operands. It stalls the front end on unresolved data hazards, then drives PC redirect and IF/ID flush on a taken branch. It also keeps branch statistics and a sticky stall-overrun error for debug.

Parameters:
MAX_STALL, 2, longest legal consecutive hazard stall for one branch; exceeding it sets err_overrun
CNT_W, 32, width of the branch/taken statistic counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_br_op  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110/111 treated as none
id_rs  in  5  source register A
id_rt  in  5  source register B (used by beq/bne only)
rf_rs_data  in  32  register-file read A
rf_rt_data  in  32  register-file read B
id_pc_plus4  in  32  PC+4 of the branch
id_imm  in  16  branch offset (words, signed)
ex_regwrite  in  1  EX-stage instruction writes a register
ex_rd  in  5  EX-stage destination
mem_regwrite  in  1  EX/MEM instruction writes a register
mem_memread  in  1  EX/MEM instruction is a load
mem_rd  in  5  EX/MEM destination
mem_alu_result  in  32  EX/MEM ALU result
wb_regwrite  in  1  MEM/WB writes a register
wb_rd  in  5  MEM/WB destination
wb_data  in  32  MEM/WB write-back value
cmp_ctrl  out  3  control code to compare unit
cmp_a  out  32  operand A to compare unit
cmp_b  out  32  operand B to compare unit
cmp_result  in  32  compare unit result; only bit 0 used
stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
pc_sel  out  1  1 = load PC with br_target
br_target  out  32  id_pc_plus4 + (sign_ext(id_imm) << 2), modulo 2^32
flush_ifid  out  1  squash the IF/ID register
br_count  out  CNT_W  branches resolved
taken_count  out  CNT_W  branches taken
err_overrun  out  1  sticky stall-overrun flag

Behaviour:
- is_br = id_valid && id_br_op in {001..101}. uses_rt = beq/bne.
- cmp_ctrl map: beq 001, bne 000, blez 110, bgtz 111, bltz 100. Non-branch drives 000.
- Operand select per source r; never forward for r == 0:
  - mem_alu_result if mem_regwrite && !mem_memread && mem_rd == r;
  - else wb_data if wb_regwrite && wb_rd == r;
  - else register-file data.
  - cmp_b = 0 when !uses_rt.
- Hazard (source used and nonzero): (ex_regwrite && ex_rd == r) || (mem_memread && mem_rd == r).
- stall = is_br && hazard, combinational. pc_sel = flush_ifid = 0 while stalling.
- Resolve, same cycle, no extra latency: is_br && !hazard. pc_sel = flush_ifid = cmp_result[0].
- FSM, registered:
  - RUN: is_br && hazard -> WAIT, stall_cnt = 1.
  - WAIT: hazard persists -> stay, stall_cnt++ (saturating). If stall_cnt == MAX_STALL and hazard still present, set err_overrun.
  - WAIT: hazard clears -> RUN, stall_cnt = 0.
  - WAIT: id_valid drops or is_br becomes 0 (external flush) -> RUN, no count update.
  - Load in EX feeding a branch gives exactly 2 stall cycles; ALU op in EX gives 1.
- Counters update on the clk edge of the resolve cycle: br_count++ and, if taken, taken_count++. Both wrap modulo 2^CNT_W.
- Reset: state RUN, stall_cnt 0, br_count 0, taken_count 0, err_overrun 0. Combinational outputs follow inputs. Reset mid-stall abandons the branch with no count.
- err_overrun clears only on reset.
- Simultaneous EX and MEM matches: forwarding priority is MEM over WB; hazard is the OR of both matches.

Decomposition:
- Shared package: branch op encodings, compare ctrl codes, FSM state enum.
- One sub-module, br_fwd_mux: per-operand forward select plus hazard detect, instantiated twice (rs, rt).

Test Plan:
- beq with rs = rt = $0, no hazards; compare unit returns 1 -> pc_sel = flush_ifid = 1. Target = pc+4 + imm·4; check pc+4 = 0x100, imm = 0xFFFF gives 0x0FC. br_count = 1, taken_count = 1.
- bne $1,$2 with ex_regwrite, ex_rd = 2 -> stall = 1 for 1 cycle. Next cycle mem_alu_result is forwarded to cmp_b and the branch resolves.
- bltz $3 after a load of $3 (load in EX, then in MEM) -> stall for exactly 2 cycles, then cmp_a = wb_data; err_overrun stays 0.
- Hazard held for 3 cycles with MAX_STALL = 2 -> err_overrun = 1 and remains 1 after the hazard clears; reset clears it.
- blez with forwarded rs = 0x80000000 -> cmp_ctrl = 110, cmp_b = 0. Branch with id_rs = 0 and ex_rd = 0 -> no stall.
- Assert reset during WAIT -> next cycle state RUN, counters 0. Preload br_count = 2^CNT_W − 1 and resolve one branch -> wraps to 0.
